// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared mode encodings and the CORDIC arctangent table.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_e;

    // atan(2^-i) as a binary angle, 2^32 == 360 degrees
    function automatic logic [31:0] atan_lut(input int idx);
        logic [31:0] v;
        case (idx)
            0:       v = 32'h2000_0000;
            1:       v = 32'h12E4_051E;
            2:       v = 32'h09FB_385B;
            3:       v = 32'h0511_11D4;
            4:       v = 32'h028B_0D43;
            5:       v = 32'h0145_D7E1;
            6:       v = 32'h00A2_F61E;
            7:       v = 32'h0051_7C55;
            8:       v = 32'h0028_BE53;
            9:       v = 32'h0014_5F2F;
            10:      v = 32'h000A_2F98;
            11:      v = 32'h0005_17CC;
            12:      v = 32'h0002_8BE6;
            13:      v = 32'h0001_45F3;
            14:      v = 32'h0000_A2FA;
            15:      v = 32'h0000_517D;
            16:      v = 32'h0000_28BE;
            17:      v = 32'h0000_145F;
            18:      v = 32'h0000_0A30;
            19:      v = 32'h0000_0518;
            20:      v = 32'h0000_028C;
            21:      v = 32'h0000_0146;
            22:      v = 32'h0000_00A3;
            23:      v = 32'h0000_0051;
            24:      v = 32'h0000_0029;
            25:      v = 32'h0000_0014;
            26:      v = 32'h0000_000A;
            27:      v = 32'h0000_0005;
            28:      v = 32'h0000_0003;
            29:      v = 32'h0000_0001;
            30:      v = 32'h0000_0001;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] atan_scaled(input int idx, input int angle_w);
        return atan_lut(idx) >> (32 - angle_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_stage
// Description : One registered CORDIC micro-rotation with valid/mode pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W       = 18,
    parameter int ANGLE_W = 32,
    parameter int SHIFT   = 0
) (
    input  logic               CLK_100MHZ,
    input  logic               RESET,
    input  logic               in_valid,
    input  logic               in_mode,
    input  logic [W-1:0]       in_x,
    input  logic [W-1:0]       in_y,
    input  logic [ANGLE_W-1:0] in_z,
    output logic               out_valid,
    output logic               out_mode,
    output logic [W-1:0]       out_x,
    output logic [W-1:0]       out_y,
    output logic [ANGLE_W-1:0] out_z
);

    localparam logic [ANGLE_W-1:0] C_ATAN = ANGLE_W'(atan_scaled(SHIFT, ANGLE_W));

    logic [W-1:0] w_x_sh;
    logic [W-1:0] w_y_sh;
    logic         w_pos;

    logic               r_valid;
    logic               r_mode;
    logic [W-1:0]       r_x;
    logic [W-1:0]       r_y;
    logic [ANGLE_W-1:0] r_z;

    assign w_x_sh = $signed(in_x) >>> SHIFT;
    assign w_y_sh = $signed(in_y) >>> SHIFT;
    // Vectoring drives y toward zero; rotation drives z toward zero.
    assign w_pos  = (in_mode == MODE_VEC) ? in_y[W-1] : ~in_z[ANGLE_W-1];

    always_ff @(posedge CLK_100MHZ) begin
        if (RESET) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_valid <= in_valid;
            r_mode  <= in_mode;
            if (w_pos) begin
                r_x <= in_x - w_y_sh;
                r_y <= in_y + w_x_sh;
                r_z <= in_z - C_ATAN;
            end else begin
                r_x <= in_x + w_y_sh;
                r_y <= in_y - w_x_sh;
                r_z <= in_z + C_ATAN;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_mode  = r_mode;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_z     = r_z;

endmodule
`default_nettype wire

// File: rtl/cordic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pipe
// Description : Fully pipelined rotation/vectoring CORDIC, one sample per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int XY_W    = 16,
    parameter int ANGLE_W = 32,
    parameter int STAGES  = 16
) (
    input  logic               CLK_100MHZ,
    input  logic               RESET,
    input  logic               in_valid,
    input  logic               in_mode,
    input  logic [XY_W-1:0]    in_x,
    input  logic [XY_W-1:0]    in_y,
    input  logic [ANGLE_W-1:0] in_angle,
    output logic               out_valid,
    output logic               out_mode,
    output logic [XY_W:0]      out_x,
    output logic [XY_W:0]      out_y,
    output logic [ANGLE_W-1:0] out_angle
);

    localparam int                 C_DW   = XY_W + 2;
    localparam logic [ANGLE_W-1:0] C_HALF = ANGLE_W'(1) << (ANGLE_W - 1);

    logic [C_DW-1:0]    w_x_ext;
    logic [C_DW-1:0]    w_y_ext;
    logic [C_DW-1:0]    w_fx;
    logic [C_DW-1:0]    w_fy;
    logic [ANGLE_W-1:0] w_fz;

    logic               w_valid [0:STAGES];
    logic               w_mode  [0:STAGES];
    logic [C_DW-1:0]    w_x     [0:STAGES];
    logic [C_DW-1:0]    w_y     [0:STAGES];
    logic [ANGLE_W-1:0] w_z     [0:STAGES];

    logic               r_f_valid;
    logic               r_f_mode;
    logic [C_DW-1:0]    r_fx;
    logic [C_DW-1:0]    r_fy;
    logic [ANGLE_W-1:0] r_fz;

    logic               r_out_valid;
    logic               r_out_mode;
    logic [XY_W:0]      r_out_x;
    logic [XY_W:0]      r_out_y;
    logic [ANGLE_W-1:0] r_out_angle;

    logic               w_unused_guard;

    assign w_x_ext = {{2{in_x[XY_W-1]}}, in_x};
    assign w_y_ext = {{2{in_y[XY_W-1]}}, in_y};

    // Quadrant pre-fold: bring the residual angle within +/-90 degrees.
    always_comb begin
        w_fx = w_x_ext;
        w_fy = w_y_ext;
        w_fz = in_angle;
        if (in_mode == MODE_VEC) begin
            w_fz = '0;
            if (in_x[XY_W-1]) begin
                w_fx = -w_x_ext;
                w_fy = -w_y_ext;
                w_fz = C_HALF;
            end
        end else if (in_angle[ANGLE_W-1] ^ in_angle[ANGLE_W-2]) begin
            w_fx = -w_x_ext;
            w_fy = -w_y_ext;
            w_fz = in_angle ^ C_HALF;
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (RESET) begin
            r_f_valid <= 1'b0;
            r_f_mode  <= 1'b0;
            r_fx      <= '0;
            r_fy      <= '0;
            r_fz      <= '0;
        end else begin
            r_f_valid <= in_valid;
            r_f_mode  <= in_mode;
            r_fx      <= w_fx;
            r_fy      <= w_fy;
            r_fz      <= w_fz;
        end
    end

    assign w_valid[0] = r_f_valid;
    assign w_mode[0]  = r_f_mode;
    assign w_x[0]     = r_fx;
    assign w_y[0]     = r_fy;
    assign w_z[0]     = r_fz;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .W       (C_DW),
            .ANGLE_W (ANGLE_W),
            .SHIFT   (i)
        ) u_stage (
            .CLK_100MHZ (CLK_100MHZ),
            .RESET      (RESET),
            .in_valid   (w_valid[i]),
            .in_mode    (w_mode[i]),
            .in_x       (w_x[i]),
            .in_y       (w_y[i]),
            .in_z       (w_z[i]),
            .out_valid  (w_valid[i+1]),
            .out_mode   (w_mode[i+1]),
            .out_x      (w_x[i+1]),
            .out_y      (w_y[i+1]),
            .out_z      (w_z[i+1])
        );
    end

    // The top guard bit is dropped without saturation; legal inputs never need it.
    assign w_unused_guard = w_x[STAGES][C_DW-1] ^ w_y[STAGES][C_DW-1];

    always_ff @(posedge CLK_100MHZ) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_angle <= '0;
        end else begin
            r_out_valid <= w_valid[STAGES];
            if (w_valid[STAGES]) begin
                r_out_mode  <= w_mode[STAGES];
                r_out_x     <= w_x[STAGES][XY_W:0];
                r_out_y     <= w_y[STAGES][XY_W:0];
                r_out_angle <= w_z[STAGES];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_mode  = r_out_mode;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_angle = r_out_angle;

endmodule
`default_nettype wire

// File: tb/tb_cordic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_pipe
// Description : Directed and sweep stimulus for cordic_pipe against ideal math.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_pipe;

    localparam int  C_LAT    = 17;
    localparam real C_K      = 1.646760258;
    localparam real C_TWO_PI = 6.283185307179586;
    localparam real C_FULL   = 4294967296.0;

    logic        CLK_100MHZ = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_mode;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_mode;
    logic [16:0] out_x;
    logic [16:0] out_y;
    logic [31:0] out_angle;

    typedef struct {
        int     edge_no;
        logic   mode;
        longint ex;
        longint ey;
        longint ea;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;

    cordic_pipe #(
        .XY_W    (16),
        .ANGLE_W (32),
        .STAGES  (16)
    ) dut (
        .CLK_100MHZ (CLK_100MHZ),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_mode    (in_mode),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_angle   (in_angle),
        .out_valid  (out_valid),
        .out_mode   (out_mode),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_angle  (out_angle)
    );

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    always @(posedge CLK_100MHZ) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input longint obs, input longint expv,
                             input longint tol, input bit wrap32);
        longint      d;
        logic [31:0] t;
        n_vec++;
        d = obs - expv;
        if (wrap32) begin
            t = d[31:0];
            d = longint'($signed(t));
        end
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at edge %0d",
                     tag, obs, expv, tol, edge_cnt);
        end
    endtask

    task automatic drive(input bit v, input bit m, input longint x, input longint y,
                         input longint a);
        exp_t e;
        real  th;
        @(posedge CLK_100MHZ);
        #2;
        in_valid = v;
        in_mode  = m;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_angle = 32'(a);
        if (v) begin
            e.edge_no = edge_cnt + 1 + C_LAT;
            e.mode    = m;
            if (!m) begin
                th   = real'(a) * C_TWO_PI / C_FULL;
                e.ex = longint'(C_K * (real'(x) * $cos(th) - real'(y) * $sin(th)));
                e.ey = longint'(C_K * (real'(x) * $sin(th) + real'(y) * $cos(th)));
                e.ea = 0;
            end else begin
                th = $atan2(real'(y), real'(x));
                if (th < 0.0) th = th + C_TWO_PI;
                e.ex = longint'(C_K * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
                e.ey = 0;
                e.ea = longint'(th / C_TWO_PI * C_FULL);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_valid"}, longint'(out_valid), 0, 0, 1'b0);
        check_val({tag, "_mode"},  longint'(out_mode),  0, 0, 1'b0);
        check_val({tag, "_x"},     longint'(out_x),     0, 0, 1'b0);
        check_val({tag, "_y"},     longint'(out_y),     0, 0, 1'b0);
        check_val({tag, "_angle"}, longint'(out_angle), 0, 0, 1'b0);
    endtask

    // Output monitor: order, latency, mode tag and values of every result.
    always @(negedge CLK_100MHZ) begin
        exp_t e;
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("stale_valid", longint'(out_valid), 0, 0, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("latency", longint'(edge_cnt), longint'(e.edge_no), 0, 1'b0);
                    check_val("mode", longint'(out_mode), longint'(e.mode), 0, 1'b0);
                    check_val("x", longint'($signed(out_x)), e.ex, 8, 1'b0);
                    check_val("y", longint'($signed(out_y)), e.ey, 8, 1'b0);
                    check_val("angle", longint'(out_angle), e.ea, 64'h2_0000, 1'b1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
                check_val("missing_valid", longint'(out_valid), 1, 0, 1'b0);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        real    th;
        longint r;
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_angle = '0;
        repeat (3) @(posedge CLK_100MHZ);
        #2;
        check_cleared("reset");
        RESET  = 1'b0;
        mon_en = 1'b1;

        // Single rotation pulse at zero angle
        drive(1'b1, 1'b0, 19429, 0, 0);
        idle(20);

        // Quadrant corners, back to back
        drive(1'b1, 1'b0, 19429, 0, 64'h4000_0000);
        drive(1'b1, 1'b0, 19429, 0, 64'h8000_0000);
        drive(1'b1, 1'b0, 19429, 0, 64'hC000_0000);
        drive(1'b1, 1'b0, -32768, 0, 64'h8000_0000);
        idle(20);

        // Vectoring, including the x<0 fold
        drive(1'b1, 1'b1, 10000, 10000, 0);
        drive(1'b1, 1'b1, -10000, 0, 0);
        drive(1'b1, 1'b1, -12000, -9000, 0);
        idle(20);

        // Contiguous full-circle sweep
        for (int i = 0; i < 360; i++)
            drive(1'b1, 1'b0, 19429, 0, (longint'(i) * 64'h1_0000_0000) / 360);
        idle(20);

        // Mixed modes with random gaps
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle(1);
            end else begin
                r  = 15000 + longint'($urandom_range(0, 3500));
                th = real'($urandom_range(0, 35999)) * C_TWO_PI / 36000.0;
                drive(1'b1, 1'(i % 3 == 0 ? 1 : $urandom_range(0, 1)),
                      longint'(real'(r) * $cos(th)), longint'(real'(r) * $sin(th)),
                      longint'($urandom));
            end
        end
        idle(20);

        // Reset with ten samples in flight; in_valid is held high during reset
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'(i % 2), 15000, 3000, longint'(i) * 64'h1000_0000);
        @(posedge CLK_100MHZ);
        #2;
        RESET    = 1'b1;
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_x     = 16'd12345;
        in_y     = 16'd0;
        in_angle = 32'h0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].edge_no > edge_cnt)
            void'(exp_q.pop_back());
        @(posedge CLK_100MHZ);
        #2;
        RESET    = 1'b0;
        in_valid = 1'b0;
        check_cleared("midrst");
        idle(25);
        drive(1'b1, 1'b0, 19429, 0, 64'h2000_0000);
        idle(20);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge CLK_100MHZ);
        check_val("drain", longint'(exp_q.size()), 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
